// File: rtl/data_mem_hs.sv
// data_mem_hs: byte-addressable little-endian data RAM with a valid/ready
// request channel and a single-entry registered response channel.
// Loads return data one cycle after acceptance; stores commit on their own
// accept edge, so a following load already sees them. Out-of-range accesses
// are rejected without touching memory and raise resp_err and err_sticky.
module data_mem_hs #(
  parameter int DATA_MEM_SIZE = 1024,
  parameter int ADDR_W        = 64,
  parameter int DATA_W        = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              err_sticky
);

  // Width of a byte index into the array; a one-byte memory still needs one bit.
  localparam int IDX_W = (DATA_MEM_SIZE > 1) ? $clog2(DATA_MEM_SIZE) : 1;
  // One extra bit so that addr + N can never wrap around.
  localparam int END_W = ADDR_W + 1;

  // Reject unsupported configurations at elaboration time.
  if (DATA_W != 64) begin : g_bad_data_w
    $fatal(1, "data_mem_hs: DATA_W must be 64");
  end
  if (DATA_MEM_SIZE < 1 || DATA_MEM_SIZE > (1 << 20)) begin : g_bad_mem_size
    $fatal(1, "data_mem_hs: DATA_MEM_SIZE must be in 1..2^20");
  end
  if (ADDR_W < IDX_W) begin : g_bad_addr_w
    $fatal(1, "data_mem_hs: ADDR_W too narrow to address the whole memory");
  end

  // Byte-enable mask for a 1/2/4/8-byte access.
  function automatic logic [7:0] size_mask(input logic [1:0] size);
    logic [7:0] mask;
    case (size)
      2'd0:    mask = 8'h01;
      2'd1:    mask = 8'h03;
      2'd2:    mask = 8'h0F;
      default: mask = 8'hFF;
    endcase
    return mask;
  endfunction

  // True when the access would touch a byte at or beyond the top of memory.
  function automatic logic range_fail(input logic [ADDR_W-1:0] addr,
                                      input logic [1:0]        size);
    logic [END_W-1:0] end_addr;
    logic [3:0]       n_bytes;
    n_bytes  = 4'd1 << size;
    end_addr = {1'b0, addr} + END_W'(n_bytes);
    return end_addr > END_W'(DATA_MEM_SIZE);
  endfunction

  logic [7:0]       mem [DATA_MEM_SIZE];

  logic             accept;
  logic             range_err_p0;
  logic [7:0]       byte_en_p0;
  logic [IDX_W-1:0] base_idx_p0;
  logic [63:0]      load_data_p0;

  logic             vld_p1;
  logic             err_p1;
  logic [63:0]      rdata_p1;
  logic             sticky_p1;

  // ---- stage p0: request decode, range check and combinational load read ----

  // The output register frees up when it is empty or being drained this edge.
  assign req_ready    = !vld_p1 || resp_ready;
  assign accept       = req_valid && req_ready;
  assign range_err_p0 = range_fail(req_addr, req_size);
  assign byte_en_p0   = size_mask(req_size);
  // An in-range access starts below DATA_MEM_SIZE, so the low bits are the full index.
  assign base_idx_p0  = req_addr[IDX_W-1:0];

  // Gather the addressed bytes little-endian, zero-extending above N bytes.
  always_comb begin
    load_data_p0 = '0;
    for (int i = 0; i < 8; i++) begin
      if (byte_en_p0[i]) begin
        load_data_p0[8*i +: 8] = mem[base_idx_p0 + IDX_W'(i)];
      end
    end
  end

  // Commit in-range stores on the accept edge; other bytes are left alone.
  always_ff @(posedge clk) begin
    if (accept && req_write && !range_err_p0) begin
      for (int i = 0; i < 8; i++) begin
        if (byte_en_p0[i]) begin
          mem[base_idx_p0 + IDX_W'(i)] <= req_wdata[8*i +: 8];
        end
      end
    end
  end

  // ---- stage p1: response register, held under backpressure ----

  // Load a response on accept, drop it when drained, otherwise hold it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1    <= 1'b0;
      err_p1    <= 1'b0;
      rdata_p1  <= '0;
      sticky_p1 <= 1'b0;
    end else if (accept) begin
      vld_p1   <= 1'b1;
      err_p1   <= range_err_p0;
      rdata_p1 <= (req_write || range_err_p0) ? 64'd0 : load_data_p0;
      if (range_err_p0) begin
        sticky_p1 <= 1'b1;
      end
    end else if (resp_ready) begin
      vld_p1 <= 1'b0;
    end
  end

  assign resp_valid = vld_p1;
  assign resp_err   = err_p1;
  assign resp_rdata = rdata_p1;
  assign err_sticky = sticky_p1;

endmodule

// File: tb/tb_data_mem_hs.sv
// Directed bench for data_mem_hs: store/load, partial access, bounds,
// backpressure, streaming against a byte model, and asynchronous reset.
module tb_data_mem_hs;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [63:0] resp_rdata;
  logic        resp_err;
  logic        err_sticky;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] model [0:1023];

  data_mem_hs #(
    .DATA_MEM_SIZE(1024),
    .ADDR_W(64),
    .DATA_W(64)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_write(req_write),
    .req_size(req_size),
    .req_addr(req_addr),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_rdata(resp_rdata),
    .resp_err(resp_err),
    .err_sticky(err_sticky)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge: presents one request, lets it be accepted on the
  // next posedge, and returns at the following negedge with req_valid low.
  task automatic send(input logic w, input logic [1:0] sz,
                      input logic [63:0] a, input logic [63:0] d);
    req_write = w;
    req_size  = sz;
    req_addr  = a;
    req_wdata = d;
    req_valid = 1'b1;
    #1;
    chk("req_ready_before_accept", {63'd0, req_ready}, 64'd1);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic check_resp(input string tag, input logic err, input logic [63:0] data);
    chk({tag, "_valid"}, {63'd0, resp_valid}, 64'd1);
    chk({tag, "_err"},   {63'd0, resp_err},   {63'd0, err});
    chk({tag, "_rdata"}, resp_rdata, data);
  endtask

  initial begin
    logic [63:0] d;
    logic [63:0] exp;
    int          a;
    int          sz;

    rst        = 1'b1;
    req_valid  = 1'b0;
    req_write  = 1'b0;
    req_size   = 2'd0;
    req_addr   = 64'd0;
    req_wdata  = 64'd0;
    resp_ready = 1'b1;

    // Reset state
    @(negedge clk);
    chk("rst_resp_valid", {63'd0, resp_valid}, 64'd0);
    chk("rst_resp_err",   {63'd0, resp_err},   64'd0);
    chk("rst_err_sticky", {63'd0, err_sticky}, 64'd0);
    chk("rst_resp_rdata", resp_rdata, 64'd0);
    chk("rst_req_ready",  {63'd0, req_ready},  64'd1);
    rst = 1'b0;
    @(negedge clk);

    // Store then load, 8 bytes
    send(1'b1, 2'd3, 64'h10, 64'h1122334455667788);
    check_resp("st8", 1'b0, 64'd0);
    send(1'b0, 2'd3, 64'h10, 64'd0);
    check_resp("ld8", 1'b0, 64'h1122334455667788);

    // Partial store and loads
    send(1'b1, 2'd0, 64'h11, 64'hAB);
    check_resp("st1", 1'b0, 64'd0);
    send(1'b0, 2'd3, 64'h10, 64'd0);
    check_resp("ld8_after_st1", 1'b0, 64'h112233445566AB88);
    send(1'b0, 2'd1, 64'h10, 64'd0);
    check_resp("ld2_at10", 1'b0, 64'h000000000000AB88);
    send(1'b0, 2'd1, 64'h11, 64'd0);
    check_resp("ld2_at11", 1'b0, 64'h00000000000066AB);
    send(1'b0, 2'd2, 64'h13, 64'd0);
    check_resp("ld4_at13", 1'b0, 64'h0000000022334455);

    // Bounds
    send(1'b1, 2'd3, 64'd1016, 64'hA1A2A3A4A5A6A7A8);
    check_resp("st8_top", 1'b0, 64'd0);
    send(1'b0, 2'd3, 64'd1016, 64'd0);
    check_resp("ld8_top", 1'b0, 64'hA1A2A3A4A5A6A7A8);
    chk("sticky_before_err", {63'd0, err_sticky}, 64'd0);
    send(1'b1, 2'd3, 64'd1017, 64'hFFFFFFFFFFFFFFFF);
    check_resp("st8_straddle", 1'b1, 64'd0);
    chk("sticky_after_err", {63'd0, err_sticky}, 64'd1);
    send(1'b0, 2'd3, 64'd1016, 64'd0);
    check_resp("ld8_top_unchanged", 1'b0, 64'hA1A2A3A4A5A6A7A8);
    chk("sticky_held", {63'd0, err_sticky}, 64'd1);
    send(1'b1, 2'd0, 64'd1023, 64'h5C);
    check_resp("st1_last", 1'b0, 64'd0);
    send(1'b0, 2'd0, 64'd1023, 64'd0);
    check_resp("ld1_last", 1'b0, 64'h5C);
    send(1'b0, 2'd1, 64'd1023, 64'd0);
    check_resp("ld2_last_straddle", 1'b1, 64'd0);
    send(1'b0, 2'd0, 64'd1024, 64'd0);
    check_resp("ld1_past_end", 1'b1, 64'd0);
    send(1'b0, 2'd3, 64'hFFFFFFFFFFFFFFFF, 64'd0);
    check_resp("ld8_all_ones", 1'b1, 64'd0);
    send(1'b0, 2'd3, 64'hFFFFFFFFFFFFFFF8, 64'd0);
    check_resp("ld8_wrap_to_zero", 1'b1, 64'd0);

    // Backpressure: hold the response, then swap in the next one on release
    send(1'b0, 2'd3, 64'h10, 64'd0);
    check_resp("bp_first", 1'b0, 64'h112233445566AB88);
    resp_ready = 1'b0;
    req_write  = 1'b0;
    req_size   = 2'd3;
    req_addr   = 64'd1016;
    req_wdata  = 64'd0;
    req_valid  = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("bp_req_ready_low", {63'd0, req_ready}, 64'd0);
      @(negedge clk);
      check_resp("bp_hold", 1'b0, 64'h112233445566AB88);
    end
    resp_ready = 1'b1;
    #1;
    chk("bp_req_ready_release", {63'd0, req_ready}, 64'd1);
    @(negedge clk);
    req_valid = 1'b0;
    check_resp("bp_swap", 1'b0, 64'h5CA2A3A4A5A6A7A8);
    @(negedge clk);
    chk("drain_valid", {63'd0, resp_valid}, 64'd0);

    // Streaming: 16 stores then 16 loads, one per cycle
    for (int i = 0; i < 16; i++) begin
      d = 64'h0123456789ABCDEF + 64'(i) * 64'h0101010101010101;
      for (int b = 0; b < 8; b++) model[256 + 8*i + b] = d[8*b +: 8];
      send(1'b1, 2'd3, 64'(256 + 8*i), d);
      check_resp("stream_st", 1'b0, 64'd0);
    end
    for (int i = 0; i < 16; i++) begin
      a   = 256 + 5*i;
      sz  = i % 4;
      exp = 64'd0;
      for (int b = 0; b < (1 << sz); b++) exp[8*b +: 8] = model[a + b];
      send(1'b0, 2'(sz), 64'(a), 64'd0);
      check_resp("stream_ld", 1'b0, exp);
    end

    // Asynchronous reset while a response is pending
    send(1'b0, 2'd3, 64'hFFFFFFFFFFFFFFFF, 64'd0);
    check_resp("pre_rst_err", 1'b1, 64'd0);
    chk("pre_rst_sticky", {63'd0, err_sticky}, 64'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_valid",  {63'd0, resp_valid}, 64'd0);
    chk("async_rst_err",    {63'd0, resp_err},   64'd0);
    chk("async_rst_sticky", {63'd0, err_sticky}, 64'd0);
    chk("async_rst_rdata",  resp_rdata, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_valid", {63'd0, resp_valid}, 64'd0);
    send(1'b0, 2'd3, 64'h10, 64'd0);
    check_resp("post_rst_ld", 1'b0, 64'h112233445566AB88);
    exp = 64'd0;
    for (int b = 0; b < 8; b++) exp[8*b +: 8] = model[256 + b];
    send(1'b0, 2'd3, 64'd256, 64'd0);
    check_resp("post_rst_ld_stream", 1'b0, exp);
    chk("post_rst_sticky", {63'd0, err_sticky}, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
